// File: rtl/key_pkg.sv
// Shared types and clock-derived defaults for the push-button conditioner.
package key_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPressChk = 2'd1,
        StHeld     = 2'd2,
        StRelChk   = 2'd3
    } key_state_e;

    localparam int unsigned CLK_HZ   = 50_000_000;
    localparam int unsigned DEB_20MS = 1_000_000;
    localparam int unsigned MS_1     = 50_000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the raw key pin, followed by polarity normalisation (1 = pressed).
module key_sync #(
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_pressed
);

    // Flops reset to the released pin level so reset never looks like a press.
    localparam logic IdleLevel = KEY_ACTIVE_LOW;

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = key_raw;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= IdleLevel;
            sync_q <= IdleLevel;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign key_pressed = KEY_ACTIVE_LOW ? ~sync_q : sync_q;

endmodule

// File: rtl/key_press_conditioner.sv
// Debounces a push-button into press/release pulses, a clean level and a hold-time measurement.
module key_press_conditioner
    import key_pkg::*;
#(
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS,
    parameter int unsigned MS_CYCLES       = MS_1,
    parameter int unsigned LONG_PRESS_MS   = 2000,
    parameter int unsigned HOLD_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_in,
    output logic              key_press,
    output logic              key_release,
    output logic              key_level,
    output logic              long_press,
    output logic [HOLD_W-1:0] hold_ms,
    output logic              hold_valid
);

    localparam int unsigned DebW  = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned TickW = cnt_width(MS_CYCLES);

    logic k;

    key_sync #(
        .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_key_sync (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_in),
        .key_pressed(k)
    );

    key_state_e        state_q, state_d;
    logic [DebW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] hold_ms_q, hold_ms_d;
    logic              key_press_q, key_press_d;
    logic              key_release_q, key_release_d;
    logic              key_level_q, key_level_d;
    logic              long_press_q, long_press_d;
    logic              hold_valid_q, hold_valid_d;

    logic deb_done;
    logic tick_done;
    logic hold_run;

    assign deb_done  = (deb_cnt_q == DebW'(DEBOUNCE_CYCLES - 1));
    assign tick_done = (tick_cnt_q == TickW'(MS_CYCLES - 1));

    always_comb begin
        state_d       = state_q;
        deb_cnt_d     = deb_cnt_q;
        tick_cnt_d    = tick_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        hold_ms_d     = hold_ms_q;
        key_level_d   = key_level_q;
        key_press_d   = 1'b0;
        key_release_d = 1'b0;
        long_press_d  = 1'b0;
        hold_valid_d  = 1'b0;
        hold_run      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (k) begin
                    state_d   = StPressChk;
                    deb_cnt_d = '0;
                end
            end
            StPressChk: begin
                if (!k) begin
                    state_d = StIdle;
                end else if (deb_done) begin
                    state_d     = StHeld;
                    key_press_d = 1'b1;
                    key_level_d = 1'b1;
                    tick_cnt_d  = '0;
                    hold_cnt_d  = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DebW'(1);
                end
            end
            StHeld: begin
                hold_run = 1'b1;
                if (!k) begin
                    state_d   = StRelChk;
                    deb_cnt_d = '0;
                end
            end
            StRelChk: begin
                if (k) begin
                    state_d  = StHeld;
                    hold_run = 1'b1;
                end else if (deb_done) begin
                    state_d       = StIdle;
                    key_release_d = 1'b1;
                    hold_valid_d  = 1'b1;
                    key_level_d   = 1'b0;
                    hold_ms_d     = hold_cnt_q;
                end else begin
                    deb_cnt_d = deb_cnt_q + DebW'(1);
                    hold_run  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Hold timer keeps running through a rejected release bounce; stops on the exit edge.
        if (hold_run) begin
            if (tick_done) begin
                tick_cnt_d = '0;
                if (!(&hold_cnt_q)) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    if (hold_cnt_q == HOLD_W'(LONG_PRESS_MS - 1)) begin
                        long_press_d = 1'b1;
                    end
                end
            end else begin
                tick_cnt_d = tick_cnt_q + TickW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            deb_cnt_q     <= '0;
            tick_cnt_q    <= '0;
            hold_cnt_q    <= '0;
            hold_ms_q     <= '0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_level_q   <= 1'b0;
            long_press_q  <= 1'b0;
            hold_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            deb_cnt_q     <= deb_cnt_d;
            tick_cnt_q    <= tick_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            hold_ms_q     <= hold_ms_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            key_level_q   <= key_level_d;
            long_press_q  <= long_press_d;
            hold_valid_q  <= hold_valid_d;
        end
    end

    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign key_level   = key_level_q;
    assign long_press  = long_press_q;
    assign hold_ms     = hold_ms_q;
    assign hold_valid  = hold_valid_q;

endmodule

// File: tb/tb_key_press_conditioner.sv
// Bench for key_press_conditioner: run-length debounce model checked every cycle, plus directed pins.
`timescale 1ns/1ps
module tb_key_press_conditioner;

    localparam int D      = 4;
    localparam int MS_A   = 10;
    localparam int MS_S   = 1;
    localparam int LONG   = 3;
    localparam int HMAX   = 65535;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_in = 1'b1;

    logic        a_press, a_rel, a_lvl, a_long, a_valid;
    logic [15:0] a_hold;
    logic        s_press, s_rel, s_lvl, s_long, s_valid;
    logic [15:0] s_hold;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    key_press_conditioner #(
        .KEY_ACTIVE_LOW (1'b1),
        .DEBOUNCE_CYCLES(D),
        .MS_CYCLES      (MS_A),
        .LONG_PRESS_MS  (LONG),
        .HOLD_W         (16)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_press  (a_press),
        .key_release(a_rel),
        .key_level  (a_lvl),
        .long_press (a_long),
        .hold_ms    (a_hold),
        .hold_valid (a_valid)
    );

    key_press_conditioner #(
        .KEY_ACTIVE_LOW (1'b1),
        .DEBOUNCE_CYCLES(D),
        .MS_CYCLES      (MS_S),
        .LONG_PRESS_MS  (LONG),
        .HOLD_W         (16)
    ) dut_s (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_press  (s_press),
        .key_release(s_rel),
        .key_level  (s_lvl),
        .long_press (s_long),
        .hold_ms    (s_hold),
        .hold_valid (s_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a change is accepted once the synchronised key differs from the accepted
    // level for D+1 consecutive clock edges; hold time is elapsed edges / MS, saturated.
    int  h1, h2, kv, run, lvl, el;
    int  e_press, e_rel, e_long_a, e_long_s, e_valid, e_hold_a, e_hold_s;
    int  long_cyc_a = -1;
    int  long_cnt_s = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            e_press = 0; e_rel = 0; e_long_a = 0; e_long_s = 0; e_valid = 0;
            if (!rst) begin
                h1 = 0; h2 = 0; run = 0; lvl = 0; el = 0; e_hold_a = 0; e_hold_s = 0;
            end else begin
                kv = h2;
                h2 = h1;
                h1 = (key_in == 1'b0) ? 1 : 0;
                run = (kv != lvl) ? run + 1 : 0;
                if (run == D + 1) begin
                    run = 0;
                    if (lvl == 1) begin
                        e_rel = 1; e_valid = 1;
                        e_hold_a = (el / MS_A > HMAX) ? HMAX : el / MS_A;
                        e_hold_s = (el / MS_S > HMAX) ? HMAX : el / MS_S;
                        lvl = 0;
                    end else begin
                        e_press = 1;
                        lvl = 1;
                        el = 0;
                    end
                end else if (lvl == 1) begin
                    el++;
                    if (el == LONG * MS_A) e_long_a = 1;
                    if (el == LONG * MS_S) e_long_s = 1;
                end
            end
            chk("a_press", a_press, e_press);
            chk("a_release", a_rel, e_rel);
            chk("a_level", a_lvl, lvl);
            chk("a_long", a_long, e_long_a);
            chk("a_valid", a_valid, e_valid);
            chk("a_hold_ms", a_hold, e_hold_a);
            chk("s_press", s_press, e_press);
            chk("s_release", s_rel, e_rel);
            chk("s_level", s_lvl, lvl);
            chk("s_long", s_long, e_long_s);
            chk("s_valid", s_valid, e_valid);
            chk("s_hold_ms", s_hold, e_hold_s);
            if (a_long) long_cyc_a = cyc;
            if (s_long) long_cnt_s++;
        end
    end

    task automatic neg_until(input int c);
        int guard = 0;
        while (cyc < c && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic pos_until(input int c);
        int guard = 0;
        while (cyc < c && guard < 200000) begin
            @(posedge clk);
            #2;
            guard++;
        end
    endtask

    int pc;

    initial begin
        // Reset with key released
        key_in = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {a_press, a_rel, a_lvl, a_long, a_valid}, 0);
        chk("rst_hold_ms", a_hold, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press: raw low first sampled at edge N, key_press visible after N+6
        key_in = 1'b0;
        @(posedge clk);
        pc = cyc + 1;                       // cyc value after edge N
        pos_until(pc + 5);
        chk("press_early", a_press, 0);
        pos_until(pc + 6);
        chk("press_at_n6", a_press, 1);
        chk("level_at_n6", a_lvl, 1);
        pc = cyc;                           // press accepted at edge P

        // Release bounce at P+16..P+17, real release sampled at P+40
        neg_until(pc + 15);
        key_in = 1'b1;
        neg_until(pc + 17);
        key_in = 1'b0;
        pos_until(pc + 25);
        chk("bounce_level", a_lvl, 1);
        neg_until(pc + 39);
        key_in = 1'b1;
        pos_until(pc + 45);
        chk("release_early", a_rel, 0);
        pos_until(pc + 46);
        chk("release_at_p46", a_rel, 1);
        chk("valid_at_p46", a_valid, 1);
        chk("hold_ms_4", a_hold, 4);
        chk("long_at_p30", long_cyc_a, pc + 30);
        repeat (10) @(negedge clk);
        chk("hold_ms_kept", a_hold, 4);

        // Glitch: three low cycles are rejected
        key_in = 1'b0;
        repeat (3) @(negedge clk);
        key_in = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_level", a_lvl, 0);

        // Reset while held, key still down at deassertion
        key_in = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_before_rst", a_lvl, 1);
        rst = 1'b0;
        #1;
        chk("rst_level_now", a_lvl, 0);
        chk("rst_no_release", a_rel, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_after_rst", a_lvl, 1);
        key_in = 1'b1;
        repeat (12) @(negedge clk);

        // Saturation on the MS_CYCLES=1 instance
        long_cnt_s = 0;
        key_in = 1'b0;
        repeat (70000) @(negedge clk);
        key_in = 1'b1;
        repeat (12) @(negedge clk);
        chk("sat_hold_ms", s_hold, HMAX);
        chk("sat_long_once", long_cnt_s, 1);
        chk("sat_level", s_lvl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/key_press_conditioner.md
Name: key_press_conditioner

Overview:
- Front-end conditioner for the board push-buttons.
- Turns a raw, bouncing, asynchronous key into clean one-cycle press/release events, a debounced level, and a hold-duration measurement.
- key_press drives the Key_0 start input of the display timer. long_press and hold_ms feed the random-number control logic.

Parameters:
KEY_ACTIVE_LOW, 1, raw key polarity (1 = pressed reads 0, as on board KEYs)
DEBOUNCE_CYCLES, 1000000, stable cycles required to accept a change (20 ms at 50 MHz); must be >= 2
MS_CYCLES, 50000, clk cycles per hold-time tick (1 ms at 50 MHz)
LONG_PRESS_MS, 2000, hold ticks at which long_press fires
HOLD_W, 16, width of hold_ms

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous, active-low reset (0 = reset)
key_in  input  1  raw push-button pin, asynchronous
key_press  output  1  one-cycle pulse on accepted press
key_release  output  1  one-cycle pulse on accepted release
key_level  output  1  debounced level, 1 = pressed
long_press  output  1  one-cycle pulse when hold reaches LONG_PRESS_MS
hold_ms  output  HOLD_W  duration of last completed press, in ticks
hold_valid  output  1  one-cycle pulse; hold_ms updated this cycle

Behaviour:
- Reset (rst=0, async):
  - All outputs 0, FSM = IDLE, all counters 0.
  - Deassertion is taken on clk.
  - If the key is already held at deassertion, it is reported as a normal press after debounce.
- Input path:
  - 2-FF synchronizer, then polarity normalisation: k = 1 means pressed.
  - All FSM decisions use k only.
- FSM states: IDLE, PRESS_CHK, HELD, REL_CHK.
  - IDLE: k=1 -> PRESS_CHK, deb_cnt <= 0.
  - PRESS_CHK: k=0 -> IDLE, no output (glitch rejected). Else, if deb_cnt == DEBOUNCE_CYCLES-1 -> HELD, pulse key_press, key_level <= 1, tick_cnt <= 0, hold_cnt <= 0. Otherwise deb_cnt++.
  - HELD: k=0 -> REL_CHK, deb_cnt <= 0.
  - REL_CHK: k=1 -> HELD, no output (bounce rejected). Else, if deb_cnt == DEBOUNCE_CYCLES-1 -> IDLE, pulse key_release and hold_valid, key_level <= 0, hold_ms <= hold_cnt. Otherwise deb_cnt++.
- Latency:
  - Let N = first clk edge sampling a new stable raw value.
  - key_press (or key_release) is high in the cycle following edge N+2+DEBOUNCE_CYCLES.
  - key_level changes on that same edge.
- Hold timing:
  - tick_cnt runs in HELD and REL_CHK. It continues across a rejected release bounce.
  - When tick_cnt == MS_CYCLES-1: tick_cnt <= 0 and hold_cnt++.
  - hold_cnt saturates at 2^HOLD_W-1, with no wrap.
  - Measured time includes the release debounce window.
- long_press:
  - Pulses exactly once per press, on the edge hold_cnt becomes LONG_PRESS_MS.
  - Never fires if released earlier.
  - Never fires again while saturated.
- Output timing:
  - Pulses are registered and exactly one cycle wide.
  - key_press and key_release never coincide.
  - hold_ms holds its value until the next hold_valid.
- Reset mid-operation: any state -> IDLE immediately. No pulses are emitted on reset.

Decomposition:
- Shared package key_pkg holds:
  - the state enum (IDLE, PRESS_CHK, HELD, REL_CHK);
  - CLK_HZ = 50_000_000;
  - derived defaults DEB_20MS = 1_000_000 and MS_1 = 50_000.
- Sub-module key_sync: 2-FF synchronizer plus polarity inversion, parameter KEY_ACTIVE_LOW, same clk/rst.
- Counters and FSM stay in the top.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, MS_CYCLES=10, LONG_PRESS_MS=3, KEY_ACTIVE_LOW=1.
1. Reset: rst=0 with key_in=1 -> all outputs 0. Pull rst low while in HELD -> key_level=0 immediately, no key_release, FSM returns to IDLE.
2. Clean press: key_in falls, first sampled at edge N -> key_press=1 for exactly the cycle after edge N+6; key_level=1 from N+6; no other pulses.
3. Glitch: key_in low for 3 cycles then high -> no key_press, key_level stays 0.
4. Hold and release: press accepted at edge P, raw release sampled at P+40 ->
   - long_press pulses after P+30;
   - key_release and hold_valid pulse after P+46;
   - hold_ms = 4.
5. Release bounce: while HELD, key_in high for 2 cycles then low again -> no key_release, key_level stays 1, hold counting uninterrupted.
6. Saturation: MS_CYCLES=1, HOLD_W=16, hold 70000 cycles -> hold_ms = 65535 at hold_valid, long_press seen exactly once.
